// File: rtl/hazard_stall_controller.sv
// ID-stage hazard and sequencing controller: load-use stalls, branch flushes,
// memory freezes and mul/div occupancy with HI/LO interlock.
module hazard_stall_controller #(
    parameter int unsigned MULDIV_LAT = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRs,
    input  logic        ID_UseRt,
    input  logic        ID_Valid,
    input  logic        ID_IsMulDiv,
    input  logic        ID_ReadsHiLo,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rw,
    input  logic        Branch_Taken,
    input  logic        Mem_Stall,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Write,
    output logic        IDEX_Bubble,
    output logic        MulDiv_Start,
    output logic        MulDiv_Busy,
    output logic        MulDiv_Done,
    output logic [31:0] Stall_Count
);

    typedef enum logic {RUN, MDBUSY} state_t;

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MULDIV_LAT - 1);

    state_t            state, next_state;
    logic [CNT_W-1:0]  count, next_count;
    logic [31:0]       stall_count;
    logic              load_use, hilo_hazard, stall_inc;

    assign load_use = EX_MemRead && (EX_Rw != 5'd0) &&
                      ((ID_UseRs && (ID_Rs == EX_Rw)) || (ID_UseRt && (ID_Rt == EX_Rw)));

    assign hilo_hazard = (state == MDBUSY) && ID_Valid && (ID_ReadsHiLo || ID_IsMulDiv);

    always_comb begin
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Write   = 1'b1;
        IDEX_Bubble  = 1'b0;
        MulDiv_Start = 1'b0;
        MulDiv_Busy  = 1'b0;
        MulDiv_Done  = 1'b0;
        stall_inc    = 1'b0;
        next_state   = state;
        next_count   = count;

        // Reset forces the idle output pattern regardless of the inputs.
        if (Reset_L) begin
            // The mul/div unit is free-running: countdown advances even under freeze.
            if (state == MDBUSY) begin
                MulDiv_Busy = 1'b1;
                if (count == '0) begin
                    MulDiv_Done = 1'b1;
                    next_state  = RUN;
                end else begin
                    next_count = count - 1'b1;
                end
            end

            if (Mem_Stall) begin
                PC_Write   = 1'b0;
                IFID_Write = 1'b0;
                IDEX_Write = 1'b0;
            end else if (Branch_Taken) begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end else if (load_use || hilo_hazard) begin
                PC_Write    = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
                stall_inc   = 1'b1;
            end else if ((state == RUN) && ID_Valid && ID_IsMulDiv) begin
                MulDiv_Start = 1'b1;
                next_state   = MDBUSY;
                next_count   = LOAD_VAL;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state       <= RUN;
            count       <= '0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (stall_inc && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
        end
    end

    assign Stall_Count = stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized and directed bench for hazard_stall_controller against a
// cycle-indexed behavioural model of the stall/flush/mul-div rules.
module tb_hazard_stall_controller;

    localparam int unsigned LAT = 8;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [4:0]  ID_Rs, ID_Rt, EX_Rw;
    logic        ID_UseRs, ID_UseRt, ID_Valid, ID_IsMulDiv, ID_ReadsHiLo;
    logic        EX_MemRead, Branch_Taken, Mem_Stall;
    logic        PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble;
    logic        MulDiv_Start, MulDiv_Busy, MulDiv_Done;
    logic [31:0] Stall_Count;

    hazard_stall_controller #(.MULDIV_LAT(LAT), .CNT_W(4)) dut (
        .CLK(CLK), .Reset_L(Reset_L),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_Valid(ID_Valid), .ID_IsMulDiv(ID_IsMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo),
        .EX_MemRead(EX_MemRead), .EX_Rw(EX_Rw), .Branch_Taken(Branch_Taken),
        .Mem_Stall(Mem_Stall),
        .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Write(IDEX_Write), .IDEX_Bubble(IDEX_Bubble),
        .MulDiv_Start(MulDiv_Start), .MulDiv_Busy(MulDiv_Busy),
        .MulDiv_Done(MulDiv_Done), .Stall_Count(Stall_Count)
    );

    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: a mul/div is described by the cycle it started in.
    int          cyc = 0;
    bit          md_active = 0;
    int          md_start_cyc = 0;
    logic [31:0] exp_stall = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic idle();
        ID_Rs = '0; ID_Rt = '0; EX_Rw = '0;
        ID_UseRs = 0; ID_UseRt = 0; ID_Valid = 0; ID_IsMulDiv = 0; ID_ReadsHiLo = 0;
        EX_MemRead = 0; Branch_Taken = 0; Mem_Stall = 0;
    endtask

    // Call with inputs already driven, shortly after a negedge.
    task automatic step();
        bit lu, hl, busy, done, stall, start, frz, br;
        #1;
        busy  = md_active && (cyc > md_start_cyc);
        done  = busy && (cyc == md_start_cyc + int'(LAT));
        lu    = EX_MemRead && (EX_Rw != 0) &&
                ((ID_UseRs && ID_Rs == EX_Rw) || (ID_UseRt && ID_Rt == EX_Rw));
        hl    = busy && ID_Valid && (ID_ReadsHiLo || ID_IsMulDiv);
        frz   = Mem_Stall;
        br    = !frz && Branch_Taken;
        stall = !frz && !br && (lu || hl);
        start = !frz && !br && !stall && !busy && ID_Valid && ID_IsMulDiv;

        check("PC_Write",    {31'd0, PC_Write},     {31'd0, !(frz || stall)});
        check("IFID_Write",  {31'd0, IFID_Write},   {31'd0, !(frz || stall)});
        check("IFID_Flush",  {31'd0, IFID_Flush},   {31'd0, br});
        check("IDEX_Write",  {31'd0, IDEX_Write},   {31'd0, !frz});
        check("IDEX_Bubble", {31'd0, IDEX_Bubble},  {31'd0, br || stall});
        check("MulDiv_Start",{31'd0, MulDiv_Start}, {31'd0, start});
        check("MulDiv_Busy", {31'd0, MulDiv_Busy},  {31'd0, busy});
        check("MulDiv_Done", {31'd0, MulDiv_Done},  {31'd0, done});
        check("Stall_Count", Stall_Count, exp_stall);

        if (done) md_active = 0;
        if (start) begin md_active = 1; md_start_cyc = cyc; end
        if (stall && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic model_reset();
        md_active = 0;
        exp_stall = '0;
    endtask

    logic [31:0] base;

    initial begin
        idle();
        Reset_L = 0;
        #2;
        check("rst_PC_Write",   {31'd0, PC_Write},    32'd1);
        check("rst_IDEX_Write", {31'd0, IDEX_Write},  32'd1);
        check("rst_Busy",       {31'd0, MulDiv_Busy}, 32'd0);
        check("rst_Stall",      Stall_Count,          32'd0);
        @(negedge CLK);
        Reset_L = 1;
        model_reset();

        // Load-use on r8, then same pattern with EX_Rw=0.
        idle(); ID_Valid = 1; EX_MemRead = 1; EX_Rw = 5'd8; ID_Rs = 5'd8; ID_UseRs = 1;
        step();
        check("lu_count", Stall_Count, 32'd1);
        idle(); ID_Valid = 1; ID_Rs = 5'd8; ID_UseRs = 1;
        step();
        idle(); ID_Valid = 1; EX_MemRead = 1; EX_Rw = 5'd0; ID_Rs = 5'd0; ID_UseRs = 1;
        step();

        // MULT then MFHI held in ID until it issues.
        idle(); ID_Valid = 1; ID_IsMulDiv = 1;
        step();
        base = exp_stall;
        idle(); ID_Valid = 1; ID_ReadsHiLo = 1;
        repeat (LAT) step();
        check("mfhi_stall_cycles", Stall_Count - base, LAT);
        step();
        check("mfhi_issued", Stall_Count - base, LAT);

        // Branch together with load-use: flush wins, no stall count.
        idle(); ID_Valid = 1; EX_MemRead = 1; EX_Rw = 5'd3; ID_Rt = 5'd3; ID_UseRt = 1;
        Branch_Taken = 1;
        step();

        // Memory freeze during MDBUSY, then let the op drain.
        idle(); ID_Valid = 1; ID_IsMulDiv = 1;
        step();
        idle();
        repeat (3) step();
        Mem_Stall = 1;
        repeat (3) step();
        idle();
        repeat (LAT) step();

        // Reset in the middle of an operation: no Done afterwards.
        idle(); ID_Valid = 1; ID_IsMulDiv = 1;
        step();
        idle();
        repeat (3) step();
        #2 Reset_L = 0;
        #1;
        check("midrst_Busy",  {31'd0, MulDiv_Busy}, 32'd0);
        check("midrst_Done",  {31'd0, MulDiv_Done}, 32'd0);
        check("midrst_PC",    {31'd0, PC_Write},    32'd1);
        check("midrst_Stall", Stall_Count,          32'd0);
        @(negedge CLK);
        Reset_L = 1;
        model_reset();
        repeat (LAT + 2) step();

        // Saturation of the stall counter.
        dut.stall_count = 32'hFFFF_FFFE;
        exp_stall = 32'hFFFF_FFFE;
        idle(); ID_Valid = 1; EX_MemRead = 1; EX_Rw = 5'd5; ID_Rs = 5'd5; ID_UseRs = 1;
        repeat (3) step();
        check("sat_hold", Stall_Count, 32'hFFFF_FFFF);

        // Random traffic with colliding register numbers.
        for (int i = 0; i < 1500; i++) begin
            ID_Rs        = 5'($urandom_range(0, 3));
            ID_Rt        = 5'($urandom_range(0, 3));
            EX_Rw        = 5'($urandom_range(0, 3));
            ID_UseRs     = 1'($urandom_range(0, 1));
            ID_UseRt     = 1'($urandom_range(0, 1));
            ID_Valid     = ($urandom_range(0, 7) != 0);
            ID_IsMulDiv  = ($urandom_range(0, 5) == 0);
            ID_ReadsHiLo = ($urandom_range(0, 3) == 0);
            EX_MemRead   = ($urandom_range(0, 2) == 0);
            Branch_Taken = ($urandom_range(0, 9) == 0);
            Mem_Stall    = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
